mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage: consumer end of the ex2memPkt interface. Registers the packet produced by
//  execute, performs load/store on the data bus via req/ack handshake, emits mem2wbPkt to writeback.
//  ex2mem.res is the effective address (loads/stores) or passthrough result (ALU ops).
// PARAMETERS
//  WAIT_MAX  255  max cycles dmem_req may stay high without dmem_ack before bus-error abort (>=1)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-low
//  stall        in   1   global pipeline stall (includes busy_o); holds input register
//  ex2mem_i     in   pkt ex2memPkt; memOp (memOp_t), stData[31:0] fields used here
//  mem2wb_o     out  pkt mem2wbPkt: pc, inst32, instValid, aux, destReg, res
//  busy_o       out  1   access in progress; must stall upstream and downstream
//  dmem_req     out  1   bus request
//  dmem_we      out  1   1=store
//  dmem_addr    out  32  word address {res[31:2],2'b00}
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_ack     in   1   access complete; rdata valid this cycle for loads
//  dmem_rdata   in   32  load data word
//  buserr_o     out  1   access aborted on timeout (valid in DONE)
//  misalign_o   out  1   misaligned access trapped (valid in DONE; see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0 at edge): input register <= 0, state IDLE, wait counter 0, load buffer 0; outputs next cycle:
//   dmem_req=0, busy_o=0, buserr_o=0, misalign_o=0, mem2wb_o.instValid=0, destReg=0.
//  Input register loads ex2mem_i on every edge with stall=0; otherwise holds.
//  FSM IDLE/ACCESS/DONE, updated at the same edge as the register load:
//   load of valid packet with memOp!=MEM_NONE -> ACCESS; any other load -> IDLE.
//   ACCESS: dmem_req=1; addr/we/be/wdata stable until ack. ack -> DONE, latch extended load data.
//   ACCESS, no ack, counter==WAIT_MAX-1 -> DONE with buserr latched, req dropped.
//   DONE: holds until next register load. dmem_ack in IDLE/DONE ignored.
//  busy_o = (state==ACCESS) combinational. Zero-wait memory (ack in first req cycle): 1 stall cycle per mem op.
//  mem2wb_o: pc/inst32/aux/destReg pass through; instValid = reg.instValid & ~busy_o;
//   res = load buffer for loads, reg.res otherwise (stores, ALU ops). Stores write destReg=0.
//  Lanes (a=res[1:0]): SB be=0001<<a, wdata={4{d[7:0]}}; SH be=0011<<{a[1],0}, wdata={2{d[15:0]}}; SW be=1111.
//  Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW whole word.
//  Reset mid-ACCESS: req deasserts after the reset edge, access abandoned, late ack ignored.
//  stall=1 during DONE: result held, no new access issued.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1, LW/SW with a!=0 -> load goes directly to DONE,
//   no dmem_req, misalign_o=1, mem2wb_o.instValid=0.
//  Undefined: misalign_o tied 0; halfword lane uses a[1] only, word ignores a; access always issued.
// STRUCTURE
//  Package (akarin.svh): memOp_t {MEM_NONE,MEM_LB,MEM_LH,MEM_LW,MEM_LBU,MEM_LHU,MEM_SB,MEM_SH,MEM_SW},
//   memState_t {MEM_IDLE,MEM_ACCESS,MEM_DONE}, mem2wbPkt typedef, memOp/stData fields in ex2memPkt.
//  Sub-module mem_lane_align (combinational): store be/wdata steering, load lane select + extension.
//  Top holds register, FSM, wait counter, load buffer.
// TESTING
//  SW res=0x100 d=0xDEADBEEF, ack 3rd req cycle -> req 3 cycles, be=1111, addr=0x100, busy_o 3 cycles.
//  LB res=0x103, rdata=0x80FFFF7F, zero-wait -> res=0xFFFFFF80; LBU same -> 0x00000080.
//  SH res=0x102 d=0x00001234 -> be=1100, wdata=0x12341234, we=1, destReg out=0.
//  ALU packet res=0x55, memOp=MEM_NONE -> no req, busy_o=0, mem2wb_o.res=0x55 same cycle as register.
//  rst=0 during ACCESS, ack 2 cycles later -> req=0 after edge, state IDLE, ack ignored, outputs reset.
//  No ack, WAIT_MAX=4 -> req 4 cycles, DONE, buserr_o=1; with MEM_MISALIGN_TRAP_EN, LW res=0x101 -> no req, misalign_o=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory-access pipeline stage.
//   memOp_t     memory operation carried by the execute packet
//   memState_t  access FSM states
//   ex2memPkt   packet from execute (res = effective address or ALU result)
//   mem2wbPkt   packet to writeback
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined,
// misaligned halfword/word accesses are trapped instead of being issued.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } memOp_t;

    typedef enum logic [1:0] {
        MEM_IDLE, MEM_ACCESS, MEM_DONE
    } memState_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst32;
        logic        instValid;
        logic [7:0]  aux;
        logic [4:0]  destReg;
        logic [31:0] res;
    } mem2wbPkt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst32;
        logic        instValid;
        logic [7:0]  aux;
        logic [4:0]  destReg;
        logic [31:0] res;
        memOp_t      memOp;
        logic [31:0] stData;
    } ex2memPkt;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    function automatic logic is_store(memOp_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_load(memOp_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    // Always evaluated so the trap-disabled build still consumes both arguments;
    // the result is forced low when trapping is not built in.
    function automatic logic is_misaligned(memOp_t op, logic [1:0] a);
        logic half;
        logic word;
        half = op inside {MEM_LH, MEM_LHU, MEM_SH};
        word = op inside {MEM_LW, MEM_SW};
        return MISALIGN_TRAP & ((half & a[0]) | (word & (a != 2'b00)));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
//   mem_op   in  operation
//   addr_lo  in  low two bits of the effective address
//   st_data  in  store data (low bytes significant)
//   ld_word  in  raw load word from the bus
//   be       out store byte enables
//   wdata    out lane-replicated store data
//   ld_data  out selected and extended load value
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  memOp_t      mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Halfword lanes only look at addr_lo[1]; a set addr_lo[0] is either
    // trapped upstream or deliberately ignored.
    always_comb begin
        ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        be      = 4'b0000;
        wdata   = st_data;
        ld_data = ld_word;
        case (mem_op)
            MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            MEM_SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            MEM_SW:  be = 4'b1111;
            MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_LBU: ld_data = {24'h000000, ld_byte};
            MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_LHU: ld_data = {16'h0000, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Registers the execute packet,
// runs a req/ack bus access for loads and stores, and presents the
// writeback packet.
//   clk, rst            clock, synchronous active-low reset
//   stall               global stall (includes busy_o); holds input register
//   ex2mem_i            packet from execute
//   mem2wb_o            packet to writeback
//   busy_o              access in progress
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata   data bus
//   buserr_o            access aborted after WAIT_MAX request cycles
//   misalign_o          misaligned access trapped (MEM_MISALIGN_TRAP_EN only)
// Optional feature macro: MEM_MISALIGN_TRAP_EN (see mem_stage_pkg).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WAIT_MAX = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  ex2memPkt    ex2mem_i,
    output mem2wbPkt    mem2wb_o,
    output logic        busy_o,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        buserr_o,
    output logic        misalign_o
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    ex2memPkt         pkt_q, pkt_d;
    memState_t        state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [31:0]      ld_buf_q, ld_buf_d;
    logic             buserr_q, buserr_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      ld_data;
    logic             new_mem;
    logic             new_trap;

    mem_lane_align u_align (
        .mem_op  (pkt_q.memOp),
        .addr_lo (pkt_q.res[1:0]),
        .st_data (pkt_q.stData),
        .ld_word (dmem_rdata),
        .be      (dmem_be),
        .wdata   (dmem_wdata),
        .ld_data (ld_data)
    );

    // Next-state logic. A register load always restarts the FSM, so the
    // access of the previous packet is dropped if stall ever falls mid-access.
    always_comb begin
        pkt_d      = pkt_q;
        state_d    = state_q;
        wait_d     = wait_q;
        ld_buf_d   = ld_buf_q;
        buserr_d   = buserr_q;
        misalign_d = misalign_q;
        new_mem    = ex2mem_i.instValid && (ex2mem_i.memOp != MEM_NONE);
        new_trap   = new_mem && is_misaligned(ex2mem_i.memOp, ex2mem_i.res[1:0]);
        if (!stall) begin
            pkt_d      = ex2mem_i;
            wait_d     = '0;
            ld_buf_d   = '0;
            buserr_d   = 1'b0;
            misalign_d = new_trap;
            if (new_trap)     state_d = MEM_DONE;
            else if (new_mem) state_d = MEM_ACCESS;
            else              state_d = MEM_IDLE;
        end else if (state_q == MEM_ACCESS) begin
            if (dmem_ack) begin
                state_d  = MEM_DONE;
                ld_buf_d = ld_data;
            end else if (wait_q == WAIT_LAST) begin
                state_d  = MEM_DONE;
                buserr_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_q      <= '0;
            state_q    <= MEM_IDLE;
            wait_q     <= '0;
            ld_buf_q   <= '0;
            buserr_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pkt_q      <= pkt_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
            ld_buf_q   <= ld_buf_d;
            buserr_q   <= buserr_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        busy_o             = (state_q == MEM_ACCESS);
        dmem_req           = busy_o;
        dmem_we            = is_store(pkt_q.memOp);
        dmem_addr          = {pkt_q.res[31:2], 2'b00};
        buserr_o           = buserr_q;
        misalign_o         = misalign_q;
        mem2wb_o.pc        = pkt_q.pc;
        mem2wb_o.inst32    = pkt_q.inst32;
        mem2wb_o.aux       = pkt_q.aux;
        mem2wb_o.instValid = pkt_q.instValid & ~busy_o & ~misalign_q;
        mem2wb_o.destReg   = is_store(pkt_q.memOp) ? 5'd0 : pkt_q.destReg;
        mem2wb_o.res       = is_load(pkt_q.memOp) ? ld_buf_q : pkt_q.res;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage. A byte-level
// memory model predicts each packet's writeback result; a bus responder
// with its own word memory answers requests with chosen latencies.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int WAIT_MAX = 4;
    localparam int NO_ACK   = 1000;
    localparam int N_PKTS   = 300;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst32;
        logic [7:0]  aux;
        logic        valid_out;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        check_res;
        logic        buserr;
        logic        misalign;
        int          req_cycles;
        int          lat;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ext_stall = 1'b0;
    logic        force_ack = 1'b0;
    logic        resp_ack = 1'b0;
    logic        stall;
    ex2memPkt    ex2mem_i;
    mem2wbPkt    mem2wb_o;
    logic        busy_o, dmem_req, dmem_we, dmem_ack, buserr_o, misalign_o;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   req_cnt = 0;
    exp_t exp_q[$];
    logic [7:0]  model_mem [int];
    logic [31:0] bus_mem [int];

    assign stall    = ext_stall | busy_o;
    assign dmem_ack = resp_ack | force_ack;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex2mem_i(ex2mem_i), .mem2wb_o(mem2wb_o),
        .busy_o(busy_o), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .buserr_o(buserr_o), .misalign_o(misalign_o)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    task automatic finish_bench();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    endtask

    function automatic logic [7:0] model_byte(input int a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    // Predicts the writeback view of a packet from the architectural rules:
    // access size, natural alignment, little-endian bytes and extension.
    task automatic model_packet(input ex2memPkt p, input int lat, output exp_t e);
        int          size;
        logic [31:0] base;
        logic [31:0] val;
        logic        st;
        st   = p.memOp inside {MEM_SB, MEM_SH, MEM_SW};
        size = (p.memOp inside {MEM_LB, MEM_LBU, MEM_SB}) ? 1 :
               (p.memOp inside {MEM_LH, MEM_LHU, MEM_SH}) ? 2 : 4;
        base = p.res & ~(32'(size) - 32'd1);
        e.pc = p.pc; e.inst32 = p.inst32; e.aux = p.aux;
        e.valid_out = p.instValid; e.dest = st ? 5'd0 : p.destReg;
        e.res = p.res; e.check_res = p.instValid;
        e.buserr = 1'b0; e.misalign = 1'b0; e.req_cycles = 0; e.lat = lat;
        e.addr = {p.res[31:2], 2'b00}; e.we = st; e.be = 4'b0000; e.wdata = 32'h0;
        if (p.instValid && p.memOp != MEM_NONE) begin
            if (TRAP && base != p.res) begin
                e.misalign = 1'b1; e.valid_out = 1'b0; e.check_res = 1'b0;
            end else begin
                e.req_cycles = (lat < WAIT_MAX) ? lat + 1 : WAIT_MAX;
                e.buserr     = (lat >= WAIT_MAX);
                if (st) begin
                    for (int i = 0; i < size; i++) begin
                        e.be = e.be | (4'b0001 << ((int'(base) + i) % 4));
                        if (!e.buserr) model_mem[int'(base) + i] = p.stData[8*i +: 8];
                    end
                    e.wdata = (size == 1) ? {4{p.stData[7:0]}} :
                              (size == 2) ? {2{p.stData[15:0]}} : p.stData;
                end else begin
                    val = 32'h0;
                    for (int i = 0; i < size; i++)
                        val = val | (32'(model_byte(int'(base) + i)) << (8 * i));
                    if (p.memOp == MEM_LB) val = {{24{val[7]}}, val[7:0]};
                    if (p.memOp == MEM_LH) val = {{16{val[15]}}, val[15:0]};
                    e.res = val;
                    e.check_res = !e.buserr;
                end
            end
        end
    endtask

    // Holds the packet on the input until an edge with stall low will load
    // it, then records the expectation for that packet.
    task automatic apply_stimulus(input ex2memPkt p, input int lat, input int stall_pct);
        exp_t e;
        int   guard;
        @(negedge clk);
        ex2mem_i  = p;
        ext_stall = ($urandom_range(0, 99) < stall_pct);
        guard     = 0;
        forever begin
            #4;
            if (!stall) break;
            guard++;
            if (guard > 200) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL load_wait: stall still 1 after %0d cycles, expected 0", guard);
                finish_bench();
            end
            @(negedge clk);
            ext_stall = ($urandom_range(0, 99) < stall_pct);
        end
        model_packet(p, lat, e);
        req_cnt = 0;
        exp_q.push_back(e);
    endtask

    function automatic ex2memPkt mk_pkt(input memOp_t op, input logic [31:0] res, input logic [31:0] d);
        ex2memPkt p;
        p = '0;
        p.pc = $urandom; p.inst32 = $urandom; p.instValid = 1'b1;
        p.aux = 8'($urandom); p.destReg = 5'($urandom_range(1, 31));
        p.memOp = op; p.res = res; p.stData = d;
        return p;
    endfunction

    // Monitor: a packet retires at an edge with stall low; compare what the
    // DUT presents just before that edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst && !stall && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("pc", mem2wb_o.pc, e.pc);
                check_output("inst32", mem2wb_o.inst32, e.inst32);
                check_output("aux", 32'(mem2wb_o.aux), 32'(e.aux));
                check_output("instValid", 32'(mem2wb_o.instValid), 32'(e.valid_out));
                if (e.valid_out) check_output("destReg", 32'(mem2wb_o.destReg), 32'(e.dest));
                if (e.check_res) check_output("res", mem2wb_o.res, e.res);
                check_output("buserr", 32'(buserr_o), 32'(e.buserr));
                check_output("misalign", 32'(misalign_o), 32'(e.misalign));
                check_output("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
            end
        end
    end

    // Bus responder with its own word-wide memory; acks after the latency
    // chosen for the packet at the head of the scoreboard.
    initial begin
        exp_t        e;
        logic        prev_req;
        int          acc;
        logic [31:0] w;
        prev_req = 1'b0;
        acc = 0;
        forever begin
            @(negedge clk);
            resp_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (rst && dmem_req) begin
                req_cnt++;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_req", 32'(dmem_req), 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!prev_req) acc = 0;
                    check_output("dmem_addr", dmem_addr, e.addr);
                    check_output("dmem_we", 32'(dmem_we), 32'(e.we));
                    if (e.we) begin
                        check_output("dmem_be", 32'(dmem_be), 32'(e.be));
                        check_output("dmem_wdata", dmem_wdata, e.wdata);
                    end
                    if (acc == e.lat) begin
                        resp_ack = 1'b1;
                        w = bus_mem.exists(int'(dmem_addr)) ? bus_mem[int'(dmem_addr)] : 32'h0;
                        if (dmem_we) begin
                            for (int k = 0; k < 4; k++)
                                if (dmem_be[k]) w[8*k +: 8] = dmem_wdata[8*k +: 8];
                            bus_mem[int'(dmem_addr)] = w;
                        end else begin
                            dmem_rdata = w;
                        end
                    end
                    acc++;
                end
            end else if (!dmem_req) begin
                resp_ack = ($urandom_range(0, 3) == 0);
            end
            prev_req = dmem_req;
        end
    end

    initial begin
        #500000;
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        finish_bench();
    end

    initial begin
        ex2memPkt p;
        int       lat;
        ex2mem_i = '0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        check_output("rst_req", 32'(dmem_req), 32'd0);
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_output("rst_buserr", 32'(buserr_o), 32'd0);
        check_output("rst_misalign", 32'(misalign_o), 32'd0);
        check_output("rst_instValid", 32'(mem2wb_o.instValid), 32'd0);
        check_output("rst_destReg", 32'(mem2wb_o.destReg), 32'd0);
        rst = 1'b1;

        apply_stimulus(mk_pkt(MEM_SW, 32'h100, 32'hDEADBEEF), 2, 0);
        apply_stimulus(mk_pkt(MEM_SW, 32'h100, 32'h80FFFF7F), 0, 0);
        apply_stimulus(mk_pkt(MEM_LB, 32'h103, 32'h0), 0, 0);
        apply_stimulus(mk_pkt(MEM_LBU, 32'h103, 32'h0), 0, 0);
        apply_stimulus(mk_pkt(MEM_SH, 32'h102, 32'h00001234), 1, 0);
        apply_stimulus(mk_pkt(MEM_NONE, 32'h55, 32'h0), 0, 0);
        apply_stimulus(mk_pkt(MEM_SW, 32'h108, 32'h11223344), NO_ACK, 0);
        apply_stimulus(mk_pkt(MEM_LW, 32'h101, 32'h0), 1, 0);
        apply_stimulus(mk_pkt(MEM_LH, 32'h103, 32'h0), 0, 30);

        for (int n = 0; n < N_PKTS; n++) begin
            p = mk_pkt(memOp_t'($urandom_range(0, 8)), 32'h100 + 32'($urandom_range(0, 31)), $urandom);
            p.instValid = ($urandom_range(0, 9) != 0);
            if (p.memOp == MEM_NONE) p.res = $urandom;
            lat = ($urandom_range(0, 9) == 0) ? NO_ACK : $urandom_range(0, 3);
            apply_stimulus(p, lat, 30);
        end
        repeat (3) apply_stimulus('0, 0, 0);

        // Reset while an access is outstanding; a late ack must not revive it.
        apply_stimulus(mk_pkt(MEM_SW, 32'h104, 32'hCAFEF00D), NO_ACK, 0);
        @(negedge clk);
        #1;
        check_output("pre_rst_req", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #3;
        check_output("midrst_req", 32'(dmem_req), 32'd0);
        check_output("midrst_busy", 32'(busy_o), 32'd0);
        check_output("midrst_instValid", 32'(mem2wb_o.instValid), 32'd0);
        check_output("midrst_destReg", 32'(mem2wb_o.destReg), 32'd0);
        ex2mem_i  = '0;
        rst       = 1'b1;
        force_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #3;
            check_output("late_ack_req", 32'(dmem_req), 32'd0);
            check_output("late_ack_buserr", 32'(buserr_o), 32'd0);
            check_output("late_ack_instValid", 32'(mem2wb_o.instValid), 32'd0);
        end
        force_ack = 1'b0;
        finish_bench();
    end

endmodule
